// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary-neural-network layer unit.
package bnn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      BWD  = 2'd2
   } state_t;

   // Majority with ties resolved high: 2*count >= total.
   function automatic logic majority_ge(input logic [31:0] count, input logic [31:0] total);
      return ((count << 1) >= total);
   endfunction

endpackage

// File: rtl/bnn_unit_if.sv
// Request/data bundle between a bnn_unit and its neighbours or driver.
interface bnn_unit_if #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 3
);
   logic             fd_prop;
   logic             bk_prop;
   logic [N_IN-1:0]  fin;
   logic [N_OUT-1:0] bin;
   logic [N_OUT-1:0] fout;
   logic [N_IN-1:0]  bout;
   logic             done;
   logic             control_out;

   modport master (
      output fd_prop, bk_prop, fin, bin,
      input  fout, bout, done, control_out
   );

   modport slave (
      input  fd_prop, bk_prop, fin, bin,
      output fout, bout, done, control_out
   );
endinterface

// File: rtl/bnn_unit_bit_sync.sv
// Two-flop synchroniser bringing the free-running oscillator bit into clk_in.
module bit_sync (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d,
   output logic q
);
   logic [1:0] sync;

   always_ff @(posedge clk_in) begin
      if (rst_in) sync <= 2'b00;
      else        sync <= {sync[0], d};
   end

   assign q = sync[1];
endmodule

// File: rtl/bnn_unit.sv
// Column-serial BNN layer: XNOR-popcount forward pass, error/stochastic-flip backward pass.
// state | meaning
// IDLE  | waiting for fd_prop (priority) or bk_prop
// FWD   | accumulating one weight column per cycle, then resolving fout
// BWD   | emitting bout and flipping weights column by column, then control_out
module bnn_unit
   import bnn_pkg::*;
#(
   parameter int N_IN  = 3,
   parameter int N_OUT = 3
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       oscillator,
   bnn_unit_if.slave  bus
);
   localparam int COL_W  = $clog2(N_IN + 1);
   localparam int ACC_W  = $clog2(N_IN + 1);
   localparam int CNT_W  = $clog2(N_OUT + 1);
   localparam int FLIP_W = $clog2(N_IN * N_OUT + 1);

   state_t state, state_nxt;
   logic [COL_W-1:0]             col;
   logic                         col_last;
   logic                         osc_s;
   logic                         load_fwd, load_bwd, fwd_step, fwd_end, bwd_step, bwd_end;

   logic [N_OUT-1:0][N_IN-1:0]   w;
   logic [N_OUT-1:0][ACC_W-1:0]  acc;
   logic [N_IN-1:0]              fin_q;
   logic [N_OUT-1:0]             bin_q;
   logic [N_OUT-1:0]             fout_q;
   logic [N_IN-1:0]              bout_q;
   logic                         done_q;
   logic                         ctrl_q;
   logic [FLIP_W-1:0]            flip_cnt;

   logic [N_IN-1:0]              sel_col;
   logic                         fin_bit;
   logic [N_OUT-1:0]             w_bit, xn, c;
   logic [CNT_W-1:0]             pc, nflag;
   logic                         bout_bit;

   bit_sync u_sync (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d      (oscillator),
      .q      (osc_s)
   );

   assign col_last = (col == COL_W'(N_IN));

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.fd_prop)      state_nxt = FWD;
            else if (bus.bk_prop) state_nxt = BWD;
         end
         FWD:     if (col_last) state_nxt = IDLE;
         BWD:     if (col_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_fwd = 1'b0;
      load_bwd = 1'b0;
      fwd_step = 1'b0;
      fwd_end  = 1'b0;
      bwd_step = 1'b0;
      bwd_end  = 1'b0;
      unique case (state)
         IDLE: begin
            load_fwd = bus.fd_prop;
            load_bwd = !bus.fd_prop && bus.bk_prop;
         end
         FWD: begin
            fwd_step = !col_last;
            fwd_end  = col_last;
         end
         BWD: begin
            bwd_step = !col_last;
            bwd_end  = col_last;
         end
         default: ;
      endcase
   end

   // One-hot column select; all zero on the resolve cycle so nothing is touched.
   for (genvar i = 0; i < N_IN; i++) begin : g_sel
      assign sel_col[i] = (col == COL_W'(i));
   end

   assign fin_bit = |(fin_q & sel_col);

   for (genvar j = 0; j < N_OUT; j++) begin : g_xnor
      assign w_bit[j] = |(w[j] & sel_col);
      assign xn[j]    = ~(fin_bit ^ w_bit[j]);
      assign c[j]     = bin_q[j] & (xn[j] == fout_q[j]);
   end

   always_comb begin
      pc    = '0;
      nflag = '0;
      for (int j = 0; j < N_OUT; j++) begin
         pc    = pc + CNT_W'(c[j]);
         nflag = nflag + CNT_W'(bin_q[j]);
      end
   end

   // Strict majority of flagged outputs; no flagged outputs means no error upstream.
   assign bout_bit = ({pc, 1'b0} > {1'b0, nflag});

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         w        <= '1;
         acc      <= '0;
         fin_q    <= '0;
         bin_q    <= '0;
         fout_q   <= '0;
         bout_q   <= '0;
         done_q   <= 1'b0;
         ctrl_q   <= 1'b0;
         flip_cnt <= '0;
         col      <= '0;
      end else begin
         done_q <= 1'b0;
         if (load_fwd) begin
            fin_q <= bus.fin;
            acc   <= '0;
            col   <= '0;
         end
         if (load_bwd) begin
            bin_q    <= bus.bin;
            flip_cnt <= '0;
            col      <= '0;
         end
         if (fwd_step) begin
            for (int j = 0; j < N_OUT; j++) acc[j] <= acc[j] + ACC_W'(xn[j]);
            col <= col + COL_W'(1);
         end
         if (fwd_end) begin
            for (int j = 0; j < N_OUT; j++) fout_q[j] <= majority_ge(32'(acc[j]), 32'(N_IN));
            done_q <= 1'b1;
         end
         if (bwd_step) begin
            bout_q <= (bout_q & ~sel_col) | (sel_col & {N_IN{bout_bit}});
            if (osc_s) begin
               for (int j = 0; j < N_OUT; j++) w[j] <= w[j] ^ (sel_col & {N_IN{c[j]}});
               flip_cnt <= flip_cnt + FLIP_W'(pc);
            end
            col <= col + COL_W'(1);
         end
         if (bwd_end) begin
            ctrl_q <= (flip_cnt == '0);
            done_q <= 1'b1;
         end
      end
   end

   assign bus.fout        = fout_q;
   assign bus.bout        = bout_q;
   assign bus.done        = done_q;
   assign bus.control_out = ctrl_q;

endmodule

// File: tb/tb_bnn_unit.sv
// Directed and randomized checks of bnn_unit (3x3 and 8x5) against a behavioural layer model.
module tb_bnn_unit;
   import bnn_pkg::*;

   logic clk = 1'b0;
   logic rst_in;
   logic osc_a, osc_b;

   always #5 clk = ~clk;

   bnn_unit_if #(.N_IN(3), .N_OUT(3)) bs ();
   bnn_unit_if #(.N_IN(8), .N_OUT(5)) bb ();

   bnn_unit #(.N_IN(3), .N_OUT(3)) u_small (
      .clk_in(clk), .rst_in(rst_in), .oscillator(osc_a), .bus(bs)
   );
   bnn_unit #(.N_IN(8), .N_OUT(5)) u_big (
      .clk_in(clk), .rst_in(rst_in), .oscillator(osc_b), .bus(bb)
   );

   int vectors     = 0;
   int miscompares = 0;

   bit [7:0] mw [2][5];
   bit [7:0] mfin [2];
   bit [7:0] mfout [2];
   bit [7:0] mbout [2];
   bit       mctrl [2];

   function automatic int nin_of(input int u);
      return (u == 0) ? 3 : 8;
   endfunction

   function automatic int nout_of(input int u);
      return (u == 0) ? 3 : 5;
   endfunction

   function automatic bit [7:0] in_mask(input int u);
      return (u == 0) ? 8'h07 : 8'hFF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd_fout(input int u);
      if (u == 0) return 32'(bs.fout);
      return 32'(bb.fout);
   endfunction

   function automatic logic [31:0] rd_bout(input int u);
      if (u == 0) return 32'(bs.bout);
      return 32'(bb.bout);
   endfunction

   function automatic logic [31:0] rd_done(input int u);
      if (u == 0) return 32'(bs.done);
      return 32'(bb.done);
   endfunction

   function automatic logic [31:0] rd_ctrl(input int u);
      if (u == 0) return 32'(bs.control_out);
      return 32'(bb.control_out);
   endfunction

   function automatic logic [31:0] rd_w(input int u, input int j);
      if (u == 0) return 32'(u_small.w[j]);
      return 32'(u_big.w[j]);
   endfunction

   task automatic drive(input int u, input bit fd, input bit bk, input logic [7:0] f, input logic [4:0] b);
      if (u == 0) begin
         bs.fd_prop = fd; bs.bk_prop = bk; bs.fin = f[2:0]; bs.bin = b[2:0];
      end else begin
         bb.fd_prop = fd; bb.bk_prop = bk; bb.fin = f; bb.bin = b;
      end
   endtask

   task automatic set_osc(input int u, input bit v);
      if (u == 0) osc_a = v;
      else        osc_b = v;
      repeat (3) @(negedge clk);
   endtask

   task automatic m_reset();
      for (int u = 0; u < 2; u++) begin
         for (int j = 0; j < 5; j++) mw[u][j] = (j < nout_of(u)) ? in_mask(u) : 8'h00;
         mfin[u] = '0; mfout[u] = '0; mbout[u] = '0; mctrl[u] = 1'b0;
      end
   endtask

   // Each output neuron fires when at least half of its XNOR matches agree.
   task automatic m_fwd(input int u, input bit [7:0] f);
      int cnt;
      mfin[u] = f & in_mask(u);
      for (int j = 0; j < nout_of(u); j++) begin
         cnt = 0;
         for (int i = 0; i < nin_of(u); i++) cnt += (mfin[u][i] == mw[u][j][i]) ? 1 : 0;
         mfout[u][j] = (2 * cnt >= nin_of(u));
      end
   endtask

   task automatic m_bwd(input int u, input bit [4:0] b, input bit osc);
      int nf, pc, flips;
      bit cj [5];
      nf = 0; flips = 0;
      for (int j = 0; j < nout_of(u); j++) nf += int'(b[j]);
      for (int i = 0; i < nin_of(u); i++) begin
         pc = 0;
         for (int j = 0; j < nout_of(u); j++) begin
            cj[j] = b[j] && (((mfin[u][i] == mw[u][j][i]) ? 1'b1 : 1'b0) == mfout[u][j]);
            pc += int'(cj[j]);
         end
         mbout[u][i] = (2 * pc > nf);
         if (osc)
            for (int j = 0; j < nout_of(u); j++)
               if (cj[j]) begin
                  mw[u][j][i] = ~mw[u][j][i];
                  flips++;
               end
      end
      mctrl[u] = (flips == 0);
   endtask

   task automatic run_pass(input int u, input bit fwd, input logic [7:0] f, input logic [4:0] b,
                           input bit both, input bit mid_bk, input string tag);
      int k, extra;
      bit seen;
      @(negedge clk);
      drive(u, fwd || both, !fwd || both, f, b);
      @(negedge clk);
      drive(u, 1'b0, 1'b0, ~f, ~b);
      seen = 0; k = 0;
      while (!seen && k < 20) begin
         @(negedge clk);
         k++;
         if (rd_done(u) == 32'd1) seen = 1;
         if (mid_bk && k == 1) drive(u, 1'b0, 1'b1, ~f, ~b);
         if (mid_bk && k == 2) drive(u, 1'b0, 1'b0, ~f, ~b);
      end
      check({tag, "_latency"}, 32'(k), 32'(nin_of(u) + 1));
      @(negedge clk);
      check({tag, "_done_pulse"}, rd_done(u), 32'd0);
      if (both || mid_bk) begin
         extra = 0;
         repeat (nin_of(u) + 3) begin
            @(negedge clk);
            if (rd_done(u) == 32'd1) extra++;
         end
         check({tag, "_no_extra_pass"}, 32'(extra), 32'd0);
      end
   endtask

   task automatic do_fwd(input int u, input logic [7:0] f, input bit both, input bit mid_bk, input string tag);
      run_pass(u, 1'b1, f, 5'($urandom), both, mid_bk, tag);
      m_fwd(u, f);
      check({tag, "_fout"}, rd_fout(u), 32'(mfout[u]));
      check({tag, "_bout_hold"}, rd_bout(u), 32'(mbout[u]));
      if (both)
         for (int j = 0; j < nout_of(u); j++) check({tag, "_w_hold"}, rd_w(u, j), 32'(mw[u][j]));
   endtask

   task automatic do_bwd(input int u, input logic [4:0] b, input bit osc, input string tag);
      set_osc(u, osc);
      run_pass(u, 1'b0, 8'($urandom), b, 1'b0, 1'b0, tag);
      m_bwd(u, b, osc);
      check({tag, "_bout"}, rd_bout(u), 32'(mbout[u]));
      check({tag, "_ctrl"}, rd_ctrl(u), 32'(mctrl[u]));
      check({tag, "_fout_hold"}, rd_fout(u), 32'(mfout[u]));
      for (int j = 0; j < nout_of(u); j++) check({tag, "_w"}, rd_w(u, j), 32'(mw[u][j]));
   endtask

   initial begin
      int extra;
      logic [7:0] f;
      logic [4:0] b;

      rst_in = 1'b1; osc_a = 1'b0; osc_b = 1'b0;
      drive(0, 1'b0, 1'b0, 8'h00, 5'h00);
      drive(1, 1'b0, 1'b0, 8'h00, 5'h00);
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check("rst_fout", rd_fout(u), 32'd0);
         check("rst_bout", rd_bout(u), 32'd0);
         check("rst_done", rd_done(u), 32'd0);
         check("rst_ctrl", rd_ctrl(u), 32'd0);
         for (int j = 0; j < nout_of(u); j++) check("rst_w", rd_w(u, j), 32'(mw[u][j]));
      end
      rst_in = 1'b0;

      do_fwd(0, 8'h07, 1'b0, 1'b0, "fwd111");
      check("fwd111_const", rd_fout(0), 32'h7);
      do_fwd(0, 8'h04, 1'b0, 1'b0, "fwd100");
      check("fwd100_const", rd_fout(0), 32'h0);
      do_fwd(0, 8'h06, 1'b0, 1'b0, "fwd110_tie");
      check("fwd110_const", rd_fout(0), 32'h7);

      do_fwd(0, 8'h07, 1'b0, 1'b0, "bk_setup");
      do_bwd(0, 5'h07, 1'b1, "bwd_flip");
      check("bwd_flip_const", rd_bout(0), 32'h7);
      do_fwd(0, 8'h07, 1'b0, 1'b0, "fwd_after_flip");
      check("fwd_after_flip_const", rd_fout(0), 32'h0);
      do_bwd(0, 5'h00, 1'b1, "bwd_noerr");
      check("bwd_noerr_ctrl_const", rd_ctrl(0), 32'h1);

      do_fwd(0, 8'h07, 1'b1, 1'b0, "arb_both");
      do_fwd(0, 8'h02, 1'b0, 1'b1, "arb_midbk");

      // Abort a backward pass after its first column has flipped.
      rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      m_reset();
      do_fwd(0, 8'h07, 1'b0, 1'b0, "midrst_setup");
      set_osc(0, 1'b1);
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 8'h07, 5'h07);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 8'h07, 5'h07);
      @(negedge clk);
      for (int j = 0; j < 3; j++) check("midrst_partial_w", rd_w(0, j), 32'h6);
      rst_in = 1'b1;
      @(negedge clk);
      m_reset();
      check("midrst_state", 32'(u_small.state), 32'(IDLE));
      check("midrst_bout", rd_bout(0), 32'd0);
      check("midrst_done", rd_done(0), 32'd0);
      for (int j = 0; j < 3; j++) check("midrst_w", rd_w(0, j), 32'(mw[0][j]));
      rst_in = 1'b0;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (rd_done(0) == 32'd1) extra++;
      end
      check("midrst_no_done", 32'(extra), 32'd0);

      for (int it = 0; it < 24; it++) begin
         f = 8'($urandom);
         b = 5'($urandom);
         do_fwd(1, f, 1'b0, 1'b0, "big_fwd");
         do_bwd(1, b, (it >= 12), "big_bwd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
